audio_mixer_n: RTL

- Parametrised N-channel audio mixer for the emu top level; the successor to the fixed PSG+OPLL+PCM sum-and-clip path.
- On each sample strobe it snapshots all channel samples, gains and pan bits.
- It converts unsigned channels to signed and accumulates one channel per clock into separate left and right accumulators.
- It then saturates each accumulator to OUT_W and presents a registered stereo sample with a valid pulse, plus clip and overrun status.

---
 rtl/audio_mixer_n.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/audio_mixer_n.sv
// N-channel stereo audio mixer.
// A sample strobe snapshots every channel's sample, gain and pan. The mixer
// then accumulates one channel per clock into signed left/right accumulators,
// scales and saturates each side to OUT_W, and presents a registered stereo
// sample with a one-cycle valid pulse, a clip counter and a sticky overrun flag.
module audio_mixer_n #(
    parameter int                  CHANNELS  = 3,
    parameter int                  IN_W      = 16,
    parameter int                  OUT_W     = 16,
    parameter logic [CHANNELS-1:0] CH_SIGNED = {CHANNELS{1'b1}}
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     sample_stb,
    input  logic [CHANNELS*IN_W-1:0] ch_data,
    input  logic [CHANNELS*4-1:0]    ch_gain,
    input  logic [CHANNELS*2-1:0]    ch_pan,
    input  logic                     clr,
    output logic [OUT_W-1:0]         out_l,
    output logic [OUT_W-1:0]         out_r,
    output logic                     out_valid,
    output logic                     busy,
    output logic [7:0]               clip_cnt,
    output logic                     overrun
);

    // Wide enough that summing every channel at full gain cannot overflow.
    localparam int ACC_W = IN_W + 4 + $clog2(CHANNELS) + 1;
    localparam int P_W   = IN_W + 5;
    localparam int SH    = OUT_W - IN_W;
    localparam int V_W   = ACC_W + SH;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_CLIP  = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CHANNELS*IN_W-1:0]  data_q, data_d;
    logic [CHANNELS*4-1:0]     gain_q, gain_d;
    logic [CHANNELS*2-1:0]     pan_q, pan_d;
    logic signed [ACC_W-1:0]   acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]   acc_r_q, acc_r_d;
    logic [OUT_W-1:0]          out_l_q, out_l_d;
    logic [OUT_W-1:0]          out_r_q, out_r_d;
    logic                      out_valid_q, out_valid_d;
    logic [7:0]                clip_cnt_q, clip_cnt_d;
    logic                      overrun_q, overrun_d;

    logic [IN_W-1:0]           cur_data;
    logic [3:0]                cur_gain;
    logic [1:0]                cur_pan;
    logic                      cur_signed;
    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   acc_l_nx;
    logic signed [ACC_W-1:0]   acc_r_nx;
    logic                      clip_evt;

    // Offset-binary channels have their MSB flipped to become two's complement;
    // gain is an unsigned 0..15 multiplier where 4 means unity.
    function automatic logic signed [ACC_W-1:0] channel_product(
        input logic [IN_W-1:0] d,
        input logic [3:0]      g,
        input logic            sgn
    );
        logic signed [IN_W-1:0] s;
        logic signed [P_W-1:0]  se;
        logic signed [P_W-1:0]  ge;
        logic signed [P_W-1:0]  p;
        s  = sgn ? signed'(d) : signed'({~d[IN_W-1], d[IN_W-2:0]});
        se = P_W'(s);
        ge = P_W'(signed'({1'b0, g}));
        p  = se * ge;
        return ACC_W'(p);
    endfunction

    // Remove the unity-gain factor of 4 (floor) and left-align to OUT_W.
    function automatic logic signed [V_W-1:0] scale(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] q;
        logic signed [V_W-1:0]   v;
        q = acc >>> 2;
        v = V_W'(q);
        return v <<< SH;
    endfunction

    // True when the scaled value does not fit in a signed OUT_W word.
    function automatic logic sat_clip(input logic signed [ACC_W-1:0] acc);
        logic signed [V_W-1:0] v;
        logic [V_W-OUT_W:0]    hi;
        v  = scale(acc);
        hi = v[V_W-1:OUT_W-1];
        return !((hi == '0) || (hi == '1));
    endfunction

    function automatic logic [OUT_W-1:0] sat_value(input logic signed [ACC_W-1:0] acc);
        logic signed [V_W-1:0] v;
        v = scale(acc);
        if (!sat_clip(acc)) begin
            return v[OUT_W-1:0];
        end else if (v[V_W-1]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    // Next-state logic: snapshot, per-channel accumulate, and on the last
    // channel register the saturated result so it is valid during CLIP.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        gain_d      = gain_q;
        pan_d       = pan_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        clip_cnt_d  = clip_cnt_q;
        overrun_d   = overrun_q;
        clip_evt    = 1'b0;
        cur_data    = '0;
        cur_gain    = '0;
        cur_pan     = '0;
        cur_signed  = 1'b1;

        for (int i = 0; i < CHANNELS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_data   = data_q[i*IN_W +: IN_W];
                cur_gain   = gain_q[i*4 +: 4];
                cur_pan    = pan_q[i*2 +: 2];
                cur_signed = CH_SIGNED[i];
            end
        end

        prod     = channel_product(cur_data, cur_gain, cur_signed);
        acc_l_nx = acc_l_q + (cur_pan[0] ? prod : '0);
        acc_r_nx = acc_r_q + (cur_pan[1] ? prod : '0);

        case (state_q)
            ST_IDLE: begin
                if (sample_stb) begin
                    data_d  = ch_data;
                    gain_d  = ch_gain;
                    pan_d   = ch_pan;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_l_d = acc_l_nx;
                acc_r_d = acc_r_nx;
                if (idx_q == IDX_W'(CHANNELS - 1)) begin
                    out_l_d     = sat_value(acc_l_nx);
                    out_r_d     = sat_value(acc_r_nx);
                    out_valid_d = 1'b1;
                    clip_evt    = sat_clip(acc_l_nx) || sat_clip(acc_r_nx);
                    state_d     = ST_CLIP;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_CLIP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear takes priority over a same-cycle increment or overrun set.
        if (clr) begin
            clip_cnt_d = '0;
            overrun_d  = 1'b0;
        end else begin
            if (clip_evt && (clip_cnt_q != 8'hFF)) begin
                clip_cnt_d = clip_cnt_q + 8'd1;
            end
            if (sample_stb && (state_q != ST_IDLE)) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any mix in progress.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            gain_q      <= '0;
            pan_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            clip_cnt_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            gain_q      <= gain_d;
            pan_q       <= pan_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            clip_cnt_q  <= clip_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign clip_cnt  = clip_cnt_q;
    assign overrun   = overrun_q;

endmodule
